// File: rtl/fast_fifo_if.sv
// rtl/fast_fifo_if.sv - write-side FIFO controller signal bundle
interface fast_fifo_if #(
  parameter int WIDTH  = 4,
  parameter int W_SIZE = 32
);
  logic              count1;
  logic [WIDTH-1:0]  pointerinw;
  logic [W_SIZE-1:0] wdata;
  logic [WIDTH-1:0]  pointeroutw;
  logic [WIDTH-2:0]  wadd;
  logic              wen;
  logic [W_SIZE-1:0] wdata_ram;
  logic              full;
  logic              almost_full;
  logic              overflow;
  logic [WIDTH-1:0]  wlevel;

  modport master (
    output count1, pointerinw, wdata,
    input  pointeroutw, wadd, wen, wdata_ram, full, almost_full, overflow, wlevel
  );

  modport slave (
    input  count1, pointerinw, wdata,
    output pointeroutw, wadd, wen, wdata_ram, full, almost_full, overflow, wlevel
  );
endinterface

// File: rtl/fast_fifo.sv
// rtl/fast_fifo.sv - dual-clock FIFO write-side controller (write clock domain)
module fast_fifo #(
  parameter int WIDTH       = 4,
  parameter int W_SIZE      = 32,
  parameter int AFULL_LEVEL = 6
) (
  input logic        clk1,
  input logic        rst1,
  fast_fifo_if.slave bus
);

  localparam logic [WIDTH-1:0] AFULL_TH = WIDTH'(AFULL_LEVEL);

  logic [WIDTH-1:0] wbin_q, wbin_d;
  logic [WIDTH-1:0] wgray_q, wgray_d;
  logic [WIDTH-1:0] rq1_q, rq2_q;
  logic [WIDTH-1:0] rbin;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] wlevel_q;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             overflow_q, overflow_d;
  logic             accept;

  // full comes from a register, so count1 never reaches full within a cycle
  assign accept = bus.count1 & ~full_q;

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of bits i..MSB
  always_comb begin
    rbin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rbin[i] = ^(rq2_q >> i);
    end
  end

  // next pointer and status, all computed from the post-write pointer so local writes show up with no extra latency
  always_comb begin
    wbin_d     = accept ? wbin_q + WIDTH'(1) : wbin_q;
    wgray_d    = wbin_d ^ (wbin_d >> 1);
    level_d    = wbin_d - rbin;
    full_d     = (wgray_d == {~rq2_q[WIDTH-1:WIDTH-2], rq2_q[WIDTH-3:0]});
    afull_d    = (level_d >= AFULL_TH);
    overflow_d = overflow_q | (bus.count1 & full_q);
  end

  // state registers and two-flop read-pointer synchroniser; reset wins over a simultaneous write
  always_ff @(posedge clk1) begin
    if (rst1) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      rq1_q      <= '0;
      rq2_q      <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
      wlevel_q   <= '0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      rq1_q      <= bus.pointerinw;
      rq2_q      <= rq1_q;
      full_q     <= full_d;
      afull_q    <= afull_d;
      overflow_q <= overflow_d;
      wlevel_q   <= level_d;
    end
  end

  assign bus.pointeroutw = wgray_q;
  assign bus.wadd        = wbin_q[WIDTH-2:0];
  assign bus.wen         = accept;
  assign bus.wdata_ram   = bus.wdata;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.overflow    = overflow_q;
  assign bus.wlevel      = wlevel_q;

endmodule

// File: tb/tb_fast_fifo.sv
// tb/tb_fast_fifo.sv - self-checking bench for fast_fifo against a count-based model
module tb_fast_fifo;

  localparam int WIDTH  = 4;
  localparam int W_SIZE = 32;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;

  logic clk1 = 1'b0;
  logic rst1;

  fast_fifo_if #(.WIDTH(WIDTH), .W_SIZE(W_SIZE)) bus ();

  fast_fifo #(.WIDTH(WIDTH), .W_SIZE(W_SIZE), .AFULL_LEVEL(AFULL)) dut (
    .clk1 (clk1),
    .rst1 (rst1),
    .bus  (bus)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad   = 0;

  // reference model: plain counts of words written and read
  int wcnt;          // accepted writes since reset
  int rcnt;          // reads the bench has reported to the write side
  int p1, p2;        // read counts presented one and two edges ago
  int exp_level;
  bit exp_full, exp_af, exp_ovf;

  logic [3:0] prev_ptr;
  bit         roll_seen;
  int         acc_writes;

  function automatic logic [3:0] gray(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle, advance the model across the edge, check all outputs after it
  task automatic cycle(input bit c, input bit r);
    int used;
    bit acc;
    bus.count1     = c;
    rst1           = r;
    bus.pointerinw = gray(rcnt);
    bus.wdata      = $urandom;
    #1;
    if (!r) chk("wen", 32'(bus.wen), 32'(c && !exp_full));
    chk("wdata_ram", bus.wdata_ram, bus.wdata);
    @(posedge clk1);
    if (r) begin
      wcnt = 0; p1 = 0; p2 = 0;
      exp_level = 0; exp_full = 0; exp_af = 0; exp_ovf = 0;
    end else begin
      used = p2;
      p2   = p1;
      p1   = rcnt;
      acc  = c && !exp_full;
      exp_ovf   = exp_ovf || (c && exp_full);
      wcnt      = wcnt + (acc ? 1 : 0);
      exp_level = wcnt - used;
      exp_full  = (exp_level == DEPTH);
      exp_af    = (exp_level >= AFULL);
    end
    #1;
    chk("pointeroutw", 32'(bus.pointeroutw), 32'(gray(wcnt)));
    chk("wadd",        32'(bus.wadd),        32'(wcnt % DEPTH));
    chk("full",        32'(bus.full),        32'(exp_full));
    chk("almost_full", 32'(bus.almost_full), 32'(exp_af));
    chk("overflow",    32'(bus.overflow),    32'(exp_ovf));
    chk("wlevel",      32'(bus.wlevel),      32'(exp_level));
    if (bus.full === 1'b1 && bus.wlevel < 4'(DEPTH))
      chk("false_full", 32'(bus.full), 32'(0));
  endtask

  logic [3:0] fill_ptrs [8];

  initial begin
    wcnt = 0; rcnt = 0; p1 = 0; p2 = 0;
    exp_level = 0; exp_full = 0; exp_af = 0; exp_ovf = 0;
    fill_ptrs[0] = 4'h1; fill_ptrs[1] = 4'h3; fill_ptrs[2] = 4'h2; fill_ptrs[3] = 4'h6;
    fill_ptrs[4] = 4'h7; fill_ptrs[5] = 4'h5; fill_ptrs[6] = 4'h4; fill_ptrs[7] = 4'hC;

    // reset held with a write request pending
    cycle(1, 1);
    cycle(1, 1);

    // fill to full with the read pointer parked at 0
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0);
      chk("fill_ptr", 32'(bus.pointeroutw), 32'(fill_ptrs[i]));
      chk("fill_wadd", 32'(bus.wadd), 32'((i + 1) % 8));
      if (i == 4) chk("af_before_6th", 32'(bus.almost_full), 32'(0));
      if (i == 5) chk("af_at_6th", 32'(bus.almost_full), 32'(1));
    end
    chk("full_at_8th", 32'(bus.full), 32'(1));
    chk("wlevel_at_8th", 32'(bus.wlevel), 32'(8));

    // writes while full are rejected and set the sticky overflow
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0);
      chk("ovf_ptr_hold", 32'(bus.pointeroutw), 32'(4'hC));
      chk("ovf_set", 32'(bus.overflow), 32'(1));
    end
    cycle(0, 0);
    chk("ovf_sticky", 32'(bus.overflow), 32'(1));

    // one read becomes visible exactly three edges after it is captured
    rcnt = 1;
    cycle(0, 0);
    chk("drain_e1_full", 32'(bus.full), 32'(1));
    cycle(0, 0);
    chk("drain_e2_full", 32'(bus.full), 32'(1));
    cycle(0, 0);
    chk("drain_e3_full", 32'(bus.full), 32'(0));
    chk("drain_e3_level", 32'(bus.wlevel), 32'(7));
    chk("drain_e3_af", 32'(bus.almost_full), 32'(1));

    // wrap-around: writes alternating with reads until 40 writes are accepted
    roll_seen  = 0;
    acc_writes = 0;
    for (int i = 0; i < 400 && acc_writes < 40; i++) begin
      prev_ptr = bus.pointeroutw;
      if (!exp_full) acc_writes++;
      cycle(1, 0);
      if (prev_ptr == 4'h8 && bus.pointeroutw == 4'h0) roll_seen = 1;
      if (rcnt < wcnt) rcnt++;
      prev_ptr = bus.pointeroutw;
      cycle(0, 0);
    end
    chk("wrap_writes", 32'(acc_writes), 32'(40));
    chk("rollover_seen", 32'(roll_seen), 32'(1));

    // random traffic with reads never passing what has been written
    for (int i = 0; i < 300; i++) begin
      if (rcnt < wcnt && $urandom_range(0, 2) != 0) rcnt++;
      cycle(1'($urandom_range(0, 1)), 0);
    end

    // drain fully, then write five words
    rcnt = wcnt;
    for (int i = 0; i < 3; i++) cycle(0, 0);
    chk("drained_level", 32'(bus.wlevel), 32'(0));
    for (int i = 0; i < 5; i++) cycle(1, 0);
    chk("pre_reset_level", 32'(bus.wlevel), 32'(5));

    // reset mid-stream with a simultaneous write: nothing is accepted
    rcnt = 0;
    cycle(1, 1);
    chk("midrst_ptr", 32'(bus.pointeroutw), 32'(0));
    chk("midrst_level", 32'(bus.wlevel), 32'(0));
    chk("midrst_ovf", 32'(bus.overflow), 32'(0));
    cycle(1, 0);
    cycle(1, 0);
    chk("post_rst_level", 32'(bus.wlevel), 32'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
